// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box and round-constant tables, word helpers
// used by the key schedule, and the state-level round primitives.
// State packing: byte n at bits [8n+:8], column c at bits [32c+:32].
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_state_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // S-box applied to each byte of a 32-bit word
  function automatic logic [31:0] SubWord(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[w[8*b +: 8]];
    return r;
  endfunction

  // [a0,a1,a2,a3] -> [a1,a2,a3,a0] with a0 in the low byte
  function automatic logic [31:0] RotWord(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] SubBytes(input logic [127:0] s);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = SBOX[s[8*n +: 8]];
    return r;
  endfunction

  // Row r rotates left by r columns
  function automatic logic [127:0] ShiftRows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[32*c + 8*w +: 8] = s[32*((c + w) % 4) + 8*w +: 8];
    return r;
  endfunction

  function automatic logic [127:0] MixColumns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round; the final round skips MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic         last,
  output logic [127:0] next
);

  logic [127:0] sub_out;
  logic [127:0] shift_out;
  logic [127:0] mix_out;

  assign sub_out   = SubBytes(state);
  assign shift_out = ShiftRows(sub_out);
  assign mix_out   = MixColumns(shift_out);
  assign next      = (last ? shift_out : mix_out) ^ rkey;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one round per clock, valid/ready on both sides.
// The round-key array comes straight from the key schedule and must stay
// stable while busy is high.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] k_sch [0:Nr],
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int CW = $clog2(Nr + 1);
  localparam logic [CW-1:0] LAST_RND = CW'(Nr);

  fsm_state_t    state;
  fsm_state_t    state_next;
  logic [CW-1:0] rnd;
  logic [127:0]  state_reg;
  logic [127:0]  round_out;
  logic          last;
  logic          load;
  logic          step;

  assign last = (rnd == LAST_RND);

  aes_round u_round (
    .state (state_reg),
    .rkey  (k_sch[rnd]),
    .last  (last),
    .next  (round_out)
  );

  // Next-state decode; a DONE handshake can accept the next block in the same cycle
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready = !rst;
          if (in_valid && !rst) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, round counter and cipher state; the counter wraps to 0 after the last round
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        state_reg <= in_data ^ k_sch[0];
        rnd       <= CW'(1);
      end else if (step) begin
        state_reg <= round_out;
        rnd       <= last ? '0 : rnd + CW'(1);
      end
    end
  end

  assign out_valid = (state == DONE);
  assign out_data  = state_reg;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboard bench for aes_cipher_iter: AES-128 instance for most scenarios,
// AES-256 instance for the 14-round vector. Expected ciphertexts come from
// published vectors or an independent byte-array AES model.
module tb_aes_cipher_iter;

  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [255:0] C3_KEY = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] C3_CT  = 128'h8960494b9049fceabf456751cab7a28e;
  localparam logic [127:0] B_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] B_PT   = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] B_CT   = 128'h320b6a19978511dcfb09dc021d842539;
  localparam logic [127:0] Z_CT   = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [127:0] ks4 [0:10];
  logic         inValid = 1'b0;
  logic         inReady;
  logic [127:0] inData = '0;
  logic         outValid;
  logic         outReady;
  logic [127:0] outData;
  logic         busy;
  logic         manualRdy = 1'b0;
  logic         randRdy = 1'b0;
  logic         randMode = 1'b0;

  logic [127:0] ks8 [0:14];
  logic         inValid8 = 1'b0;
  logic         inReady8;
  logic [127:0] inData8 = '0;
  logic         outValid8;
  logic         outReady8 = 1'b0;
  logic [127:0] outData8;
  logic         busy8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [127:0] sbq [$];
  logic [127:0] sbq8 [$];
  int hsCyc [$];
  logic [7:0] tbSbox [0:255];

  assign outReady = randMode ? randRdy : manualRdy;

  aes_cipher_iter #(.Nk(4)) dut (
    .clk(clk), .rst(rst), .k_sch(ks4),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData), .busy(busy)
  );

  aes_cipher_iter #(.Nk(8)) dut8 (
    .clk(clk), .rst(rst), .k_sch(ks8),
    .in_valid(inValid8), .in_ready(inReady8), .in_data(inData8),
    .out_valid(outValid8), .out_ready(outReady8), .out_data(outData8), .busy(busy8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    randRdy = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, expected DUT response", name);
  endtask

  // Monitors: compare each output handshake against the oldest expected entry
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (sbq.size() == 0) timeoutFail("unexpected_output_128");
      else checkOutput("ciphertext_128", outData, sbq.pop_front());
      hsCyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!rst && outValid8 && outReady8) begin
      if (sbq8.size() == 0) timeoutFail("unexpected_output_256");
      else checkOutput("ciphertext_256", outData8, sbq8.pop_front());
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      tbSbox[x] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {tbSbox[w[31:24]], tbSbox[w[23:16]], tbSbox[w[15:8]], tbSbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] roundKey(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[7:0], t[31:8]});
        t[7:0] = t[7:0] ^ rc;
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endfunction

  function automatic logic [127:0] aesModel(input logic [127:0] pt, input logic [255:0] key, input int nk);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] rk;
    logic [127:0] res;
    int nr = nk + 6;
    rk = roundKey(key, nk, 0);
    for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ rk[8*n +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) s[n] = tbSbox[s[n]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end
      end else begin
        for (int n = 0; n < 16; n++) s[n] = t[n];
      end
      rk = roundKey(key, nk, r);
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rk[8*n +: 8];
    end
    for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic loadKey4(input logic [127:0] key);
    for (int r = 0; r <= 10; r++) ks4[r] = roundKey({128'b0, key}, 4, r);
  endtask

  // Offer one block, push its expected ciphertext, return the accept cycle
  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] exp, output int acc);
    int n = 0;
    inData = pt;
    inValid = 1'b1;
    forever begin
      @(negedge clk);
      if (inReady) break;
      n++;
      if (n > 300) break;
    end
    if (!inReady) timeoutFail("in_ready_wait");
    else sbq.push_back(exp);
    @(posedge clk);
    #1;
    acc = cyc;
    inValid = 1'b0;
  endtask

  task automatic waitOutValid(input int limit, input int acc, output int lat);
    int n = 0;
    while (!outValid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!outValid) timeoutFail("out_valid_wait");
    lat = cyc - acc;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0 || busy) timeoutFail("drain");
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int acc;
    int acc2;
    int lat;
    int n;
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] exp;

    buildSbox();
    for (int r = 0; r <= 10; r++) ks4[r] = '0;
    for (int r = 0; r <= 14; r++) ks8[r] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_in_ready", inReady, 0);
    checkOutput("reset_out_data", outData, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", inReady, 1);

    // FIPS-197 C.1 with latency
    loadKey4(C1_KEY);
    manualRdy = 1'b1;
    applyStimulus(C1_PT, C1_CT, acc);
    waitOutValid(30, acc, lat);
    checkOutput("c1_latency", lat, 10);
    drain(50);

    // Other directed AES-128 vectors
    loadKey4(128'h0);
    applyStimulus(128'h0, Z_CT, acc);
    drain(50);
    loadKey4(B_KEY);
    applyStimulus(B_PT, B_CT, acc);
    drain(50);

    // Backpressure: output held for 20 cycles
    manualRdy = 1'b0;
    loadKey4(C1_KEY);
    applyStimulus(C1_PT, C1_CT, acc);
    waitOutValid(30, acc, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", outValid, 1);
      checkOutput("bp_out_data", outData, C1_CT);
      checkOutput("bp_in_ready", inReady, 0);
      checkOutput("bp_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    manualRdy = 1'b1;
    @(posedge clk);
    #1;
    manualRdy = 1'b0;
    checkOutput("bp_after_out_valid", outValid, 0);
    checkOutput("bp_after_busy", busy, 0);
    checkOutput("bp_after_in_ready", inReady, 1);
    checkOutput("bp_queue_empty", sbq.size(), 0);

    // Back-to-back with out_ready held high
    manualRdy = 1'b1;
    hsCyc.delete();
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = aesModel(pt, {128'b0, C1_KEY}, 4);
    applyStimulus(C1_PT, C1_CT, acc);
    applyStimulus(pt, exp, acc2);
    drain(60);
    checkOutput("b2b_handshakes", hsCyc.size(), 2);
    if (hsCyc.size() == 2) begin
      checkOutput("b2b_spacing", hsCyc[1] - hsCyc[0], 11);
      checkOutput("b2b_accept_cycle", acc2, hsCyc[0] + 1);
    end

    // Reset in round 5
    applyStimulus(C1_PT, C1_CT, acc);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out_valid", outValid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_in_ready", inReady, 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_release_in_ready", inReady, 1);
    applyStimulus(C1_PT, C1_CT, acc);
    drain(50);

    // FIPS-197 C.3 on the AES-256 instance
    for (int r = 0; r <= 14; r++) ks8[r] = roundKey(C3_KEY, 8, r);
    inData8 = C1_PT;
    inValid8 = 1'b1;
    @(negedge clk);
    checkOutput("c3_in_ready", inReady8, 1);
    sbq8.push_back(C3_CT);
    @(posedge clk);
    #1;
    acc = cyc;
    inValid8 = 1'b0;
    outReady8 = 1'b1;
    n = 0;
    while (!outValid8 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!outValid8) timeoutFail("c3_out_valid_wait");
    checkOutput("c3_latency", cyc - acc, 14);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("c3_queue_empty", sbq8.size(), 0);
    checkOutput("c3_busy", busy8, 0);

    // Random keys/plaintexts with random input gaps and output stalls
    randMode = 1'b1;
    for (int g = 0; g < 250; g++) begin
      drain(400);
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      loadKey4(key);
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        applyStimulus(pt, aesModel(pt, {128'b0, key}, 4), acc);
      end
    end
    drain(400);
    randMode = 1'b0;
    checkOutput("final_queue_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
